ps2_key_tracker: RTL and testbench

Parametrised PS/2 keyboard front end that replaces the single-shot keyboard path. It receives full 11-bit PS/2 frames with parity, stop-bit and inter-bit timeout checking, and decodes make, break (F0) and extended (E0) prefixes. It maintains a held-key bitmap for a configurable key map, plus one-cycle press/release pulses. It sits between the PS/2 pins and the input-merge logic that builds `UserInput`.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_frame_rx.sv | 115 +++++++++++
 rtl/ps2_key_tracker.sv | 87 ++++++++
 tb/tb_ps2_key_tracker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } Ps2State;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int DEFAULT_NUM_KEYS = 13;

  // {ext, scan}: digits 1..7, '=', '-', up, down, left, right
  localparam logic [8:0] DEFAULT_KEY_MAP [DEFAULT_NUM_KEYS] = '{
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
    9'h055, 9'h04E, 9'h175, 9'h172, 9'h16B, 9'h174
  };

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, 11-bit frame FSM, inter-bit timeout.
//   state  | meaning
//   IDLE   | waiting for a start bit (falling edge with data low)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking stop bit and odd parity, emitting result pulse
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // One extra flop on the clock chain holds the previous synchronised level.
  logic [SYNC_STAGES:0]   clk_s;
  logic [SYNC_STAGES-1:0] data_s;
  logic                   fall;
  logic                   data_bit;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_s  <= '1;
      data_s <= '1;
    end else begin
      clk_s  <= {clk_s[SYNC_STAGES-1:0], ps2_clk};
      data_s <= {data_s[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall     = clk_s[SYNC_STAGES] & ~clk_s[SYNC_STAGES-1];
  assign data_bit = data_s[SYNC_STAGES-1];

  Ps2State       state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      par_bit     <= 1'b0;
      tcnt        <= '0;
      rx_valid    <= 1'b0;
      rx_byte     <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;

      // A falling edge takes priority over the terminal count.
      if (state == IDLE || fall) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt        <= '0;
        state       <= IDLE;
        err_timeout <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              shift   <= '0;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift[bit_cnt] <= data_bit;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_bit;
            state   <= STOP;
          end
          STOP: begin
            if (^{shift, par_bit} != 1'b1) begin
              err_parity <= 1'b1;
            end else if (!data_bit) begin
              err_frame <= 1'b1;
            end else begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receive, E0/F0 prefix decode, held-key bitmap.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int         NUM_KEYS       = DEFAULT_NUM_KEYS,
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [8:0] KEY_MAP [NUM_KEYS] = DEFAULT_KEY_MAP
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                rx_valid,
  output logic [7:0]          rx_byte,
  output logic                err_parity,
  output logic                err_frame,
  output logic                err_timeout
);

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .err_timeout(err_timeout)
  );

  logic                ext;
  logic                brk;
  logic [NUM_KEYS-1:0] hit;

  // Scan from the top so the lowest matching index is left in the one-hot.
  always_comb begin
    hit = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_MAP[i] == {ext, rx_byte}) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (err_parity || err_frame || err_timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            key_held    <= key_held & ~(hit & key_held);
            key_release <= hit & key_held;
          end else begin
            key_held  <= key_held | hit;
            key_press <= hit & ~key_held;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench: PS/2 frames driven on the pins, expected pulses queued and matched.
module tb_ps2_key_tracker;

  localparam int NK   = 13;
  localparam int SS   = 2;
  localparam int TC   = 300;
  localparam int HALF = 8;

  localparam int EV_RX = 1, EV_PAR = 2, EV_FRM = 3, EV_TO = 4, EV_PRESS = 5, EV_REL = 6;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic [NK-1:0] key_held, key_press, key_release;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          err_parity, err_frame, err_timeout;

  ps2_key_tracker #(
    .NUM_KEYS      (NK),
    .SYNC_STAGES   (SS),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_held   (key_held),
    .key_press  (key_press),
    .key_release(key_release),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  ev_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_rx = -10;
  int            last_to = 0;
  int            last_fall = 0;
  logic [8:0]    m_map [NK] = '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
                                9'h055, 9'h04E, 9'h175, 9'h172, 9'h16B, 9'h174};
  logic [NK-1:0] m_held = '0;
  logic          m_ext = 1'b0;
  logic          m_brk = 1'b0;
  logic [7:0]    m_last = 8'h00;

  function automatic void push(int kind, logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(int kind, logic [15:0] val);
    ev_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL unexpected_event kind=%0d got=%h expected=none", kind, val);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      assert (e.kind === kind && e.val === val) else begin
        errors++;
        $error("FAIL event got kind=%0d val=%h expected kind=%0d val=%h", kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid) begin
      last_rx = cyc;
      check_ev(EV_RX, {8'h00, rx_byte});
    end
    if (err_parity) check_ev(EV_PAR, 16'h0);
    if (err_frame) check_ev(EV_FRM, 16'h0);
    if (err_timeout) begin
      last_to = cyc;
      check_ev(EV_TO, 16'h0);
    end
    if (key_press != '0 || key_release != '0) begin
      if (key_press != '0) check_ev(EV_PRESS, 16'(key_press));
      if (key_release != '0) check_ev(EV_REL, 16'(key_release));
      checks++;
      assert (cyc === last_rx + 1) else begin
        errors++;
        $error("FAIL key_pulse_latency got=%0d expected=%0d", cyc - last_rx, 1);
      end
    end
  endtask

  task automatic drive_bit(logic b);
    ps2_data = b;
    repeat (HALF) tick();
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic model_byte(logic [7:0] b);
    int idx;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      idx = -1;
      for (int i = 0; i < NK; i++)
        if (idx < 0 && m_map[i] == {m_ext, b}) idx = i;
      if (idx >= 0) begin
        if (m_brk && m_held[idx]) begin
          m_held[idx] = 1'b0;
          push(EV_REL, 16'(1) << idx);
        end else if (!m_brk && !m_held[idx]) begin
          m_held[idx] = 1'b1;
          push(EV_PRESS, 16'(1) << idx);
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(logic [7:0] b, logic flip_par = 1'b0, logic stop = 1'b1);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ flip_par;
    bits = {stop, par, b, 1'b0};
    if (flip_par) begin
      push(EV_PAR, 16'h0);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (!stop) begin
      push(EV_FRM, 16'h0);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      push(EV_RX, {8'h00, b});
      m_last = b;
      model_byte(b);
    end
    for (int i = 0; i < 11; i++) drive_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (40) tick();
    checks++;
    assert (key_held === m_held) else begin
      errors++;
      $error("FAIL key_held after %h got=%h expected=%h", b, key_held, m_held);
    end
    checks++;
    assert (rx_byte === m_last) else begin
      errors++;
      $error("FAIL rx_byte_hold got=%h expected=%h", rx_byte, m_last);
    end
  endtask

  task automatic check_all_zero(string tag);
    checks++;
    assert ({key_held, key_press, key_release, rx_valid, rx_byte,
             err_parity, err_frame, err_timeout} === '0) else begin
      errors++;
      $error("FAIL %s got held=%h byte=%h pulses=%b expected=all zero", tag, key_held, rx_byte,
             {rx_valid, err_parity, err_frame, err_timeout});
    end
  endtask

  task automatic reset_pulse(string tag);
    sys_rst_n = 1'b0;
    ps2_data  = 1'b1;
    ps2_clk   = 1'b1;
    repeat (4) tick();
    check_all_zero(tag);
    sys_rst_n = 1'b1;
    m_held = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_last = 8'h00;
    repeat (20) tick();
  endtask

  initial begin
    repeat (5) tick();
    check_all_zero("in_reset");
    sys_rst_n = 1'b1;
    repeat (1000) tick();
    check_all_zero("idle_1000");

    // Make, then typematic repeat
    send_frame(8'h16);
    send_frame(8'h16);
    // Break, then break of a key already up
    send_frame(8'hF0);
    send_frame(8'h16);
    send_frame(8'hF0);
    send_frame(8'h16);
    // Extended key up arrow, bare 75 has no mapping
    send_frame(8'hE0);
    send_frame(8'h75);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    send_frame(8'h75);

    // Errors: held state survives, prefix is dropped
    send_frame(8'h16);
    send_frame(8'h16, 1'b1);
    send_frame(8'h1E, 1'b0, 1'b0);
    send_frame(8'hE0);
    send_frame(8'h26, 1'b1);
    send_frame(8'h75);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h26, 1'b0, 1'b0);
    send_frame(8'h16);

    // Timeout after start plus 4 data bits
    push(EV_TO, 16'h0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TC + 40) tick();
    checks++;
    assert (last_to - last_fall >= TC && last_to - last_fall <= TC + SS + 3) else begin
      errors++;
      $error("FAIL timeout_delay got=%0d expected=%0d..%0d", last_to - last_fall, TC, TC + SS + 3);
    end
    send_frame(8'h1E);

    // Reset mid-frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset_pulse("reset_mid_frame");
    // Reset between F0 and the code byte
    send_frame(8'hF0);
    reset_pulse("reset_mid_prefix");
    send_frame(8'h1E);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_events got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
